// File: rtl/c_fetch_ctrl_if.sv
// Instruction-cache request/response bus between the fetch controller and the icache.
interface c_fetch_ctrl_if;
  logic        icache_req_o;
  logic [31:0] icache_addr_o;
  logic        icache_valid_i;
  logic [31:0] icache_instr_i;

  modport master (
    output icache_req_o, icache_addr_o,
    input  icache_valid_i, icache_instr_i
  );

  modport slave (
    input  icache_req_o, icache_addr_o,
    output icache_valid_i, icache_instr_i
  );
endinterface

// File: rtl/c_fetch_ctrl.sv
// Fetch controller for a core with a compressed-instruction expander between icache and decode.
// Tracks the 16-bit-granular PC separately from the word-aligned icache fetch address.
module c_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 br_taken_i,
  input  logic [31:0]          br_pc_i,
  input  logic                 stall_i,
  c_fetch_ctrl_if.master       icache,
  output logic [31:0]          pc_ff_o,
  output logic [31:0]          instr_un_o,
  output logic                 icache_valid_o,
  input  logic                 cext_stall_i,
  input  logic [31:0]          cext_instr_i,
  input  logic                 cext_is_comp_i,
  input  logic                 cext_illegal_i,
  output logic                 if_valid_o,
  output logic [31:0]          if_instr_o,
  output logic [31:0]          if_pc_o,
  output logic                 if_illegal_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DROP} state_t;

  localparam logic [31:0] RESET_PC_H = RESET_PC & ~32'd1;
  localparam logic [31:0] RESET_FA   = RESET_PC & ~32'd3;

  state_t      r_state;
  logic [31:0] r_pc_ff;
  logic [31:0] r_fetch_addr;
  logic [31:0] r_hold_instr;
  logic        r_hold_illegal;
  logic        r_hold_comp;

  logic        w_resp;
  logic        w_redirect;
  logic        w_capture;
  logic        w_comp;
  logic [31:0] w_next_pc;

  assign w_resp     = !reset && (r_state == S_REQ) && icache.icache_valid_i;
  assign w_redirect = !reset && (r_state != S_IDLE) && br_taken_i;
  assign w_capture  = w_resp && !w_redirect && !cext_stall_i && stall_i;
  // A held instruction must advance by its own size, not by whatever the expander shows now.
  assign w_comp     = (r_state == S_HOLD) ? r_hold_comp : cext_is_comp_i;
  assign w_next_pc  = r_pc_ff + (w_comp ? 32'd2 : 32'd4);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pc_ff      <= RESET_PC_H;
      r_fetch_addr <= RESET_FA;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (br_taken_i) begin
            r_pc_ff      <= br_pc_i & ~32'd1;
            r_fetch_addr <= br_pc_i & ~32'd3;
            r_state      <= icache.icache_valid_i ? S_REQ : S_DROP;
          end else if (icache.icache_valid_i) begin
            if (cext_stall_i) begin
              r_fetch_addr <= r_fetch_addr + 32'd4;
            end else if (!stall_i) begin
              r_pc_ff      <= w_next_pc;
              r_fetch_addr <= w_next_pc & ~32'd3;
            end else begin
              r_state <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (br_taken_i) begin
            r_pc_ff      <= br_pc_i & ~32'd1;
            r_fetch_addr <= br_pc_i & ~32'd3;
            r_state      <= S_REQ;
          end else if (!stall_i) begin
            r_pc_ff      <= w_next_pc;
            r_fetch_addr <= w_next_pc & ~32'd3;
            r_state      <= S_REQ;
          end
        end
        S_DROP: begin
          if (br_taken_i) begin
            r_pc_ff      <= br_pc_i & ~32'd1;
            r_fetch_addr <= br_pc_i & ~32'd3;
          end else if (icache.icache_valid_i) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // NOTE: holding registers carry no reset; they are only observed in HOLD, which is always entered through a capture.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_hold_instr   <= cext_instr_i;
      r_hold_illegal <= cext_illegal_i;
      r_hold_comp    <= cext_is_comp_i;
    end
  end

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    icache.icache_req_o  = 1'b0;
    icache.icache_addr_o = r_fetch_addr;
    pc_ff_o              = reset ? RESET_PC_H : r_pc_ff;
    icache_valid_o       = 1'b0;
    instr_un_o           = '0;
    if_valid_o           = 1'b0;
    if_instr_o           = '0;
    if_pc_o              = '0;
    if_illegal_o         = 1'b0;
    if (!reset) begin
      icache.icache_req_o = (r_state == S_REQ);
      icache_valid_o      = w_resp;
      instr_un_o          = w_resp ? icache.icache_instr_i : 32'd0;
      if (!w_redirect) begin
        if (r_state == S_HOLD) begin
          if_valid_o   = 1'b1;
          if_instr_o   = r_hold_instr;
          if_pc_o      = r_pc_ff;
          if_illegal_o = r_hold_illegal;
        end else if (w_resp && !cext_stall_i && !stall_i) begin
          if_valid_o   = 1'b1;
          if_instr_o   = cext_instr_i;
          if_pc_o      = r_pc_ff;
          if_illegal_o = cext_illegal_i;
        end
      end
    end
  end

endmodule
